// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel word assembler with start-of-frame resync, abort and a
// single-entry output holding register that flags dropped words.
module s2p_frame_ctrl #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        din_valid,
   input  logic                        din,
   input  logic                        sof,
   input  logic                        abort,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic [$clog2(DATA_WIDTH):0] bit_count,
   output logic                        busy,
   output logic                        overflow,
   input  logic                        clear_ovf
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic [0:0]            state, state_nxt;
   logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
   logic [CW-1:0]         cnt_nxt;
   logic [DATA_WIDTH-1:0] word;
   logic                  offer, load, pop;

   assign word = {sreg[DATA_WIDTH-2:0], din};

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = bit_count;
      offer     = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
         sreg_nxt  = '0;
         cnt_nxt   = '0;
      end else if (din_valid) begin
         if (sof) begin
            // A sof mid-word silently discards the partial word.
            state_nxt = SHIFT;
            sreg_nxt  = {{(DATA_WIDTH-1){1'b0}}, din};
            cnt_nxt   = CW'(1);
         end else if (state == SHIFT) begin
            sreg_nxt = word;
            if (bit_count == LAST_BIT) begin
               offer   = 1'b1;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = bit_count + 1'b1;
            end
         end
      end
   end

   assign pop  = dout_valid && dout_ready;
   assign load = offer && (!dout_valid || dout_ready);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_count <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bit_count <= cnt_nxt;
         busy      <= (state_nxt == SHIFT);
      end
   end

   // Holding register: a pop and a load in the same cycle keep dout_valid high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (load) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (pop) begin
            dout_valid <= 1'b0;
         end
         if (offer && !load)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

endmodule
